// File: rtl/fetch_pc_unit.sv
// PC owner and instruction fetch front end: fetches over imem req/ack, holds the word for decode,
// and commits the next PC on exec_done. Optional FETCH_PERF_CNT_EN adds retired/stall counters.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        bgtz,
    input  logic        jal,
    input  logic        jsp,
    input  logic        alu_zero,
    input  logic        alu_gtz,
    input  logic [31:0] jsp_target,
    output logic [31:0] link_pc,
    output logic [31:0] pc,
    output logic [1:0]  state_dbg
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc4;
    logic [31:0] br_offset;
    logic        br_taken;
    logic [31:0] next_pc;
    logic        fetch_hit;
    logic        exec_hit;

    // Handshake: imem_req is a valid that, once raised in FETCH, holds with a stable imem_addr
    // until imem_ack is seen on a rising edge; ack is a one-cycle ready/data strobe, ignored outside FETCH.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == EXEC);
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc          = pc_q;
    assign link_pc     = pc4;
    assign state_dbg   = state_q;

    assign fetch_hit = (state_q == FETCH) && imem_ack;
    assign exec_hit  = (state_q == EXEC) && exec_done;

    assign pc4       = pc_q + 32'd4;
    assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign br_taken  = (branch && alu_zero) || (bgtz && alu_gtz);

    // jsp outranks jal, which outranks a taken conditional branch.
    always_comb begin
        next_pc = pc4;
        if (jsp) begin
            next_pc = {jsp_target[31:2], 2'b00};
        end else if (jal) begin
            next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
        end else if (br_taken) begin
            next_pc = pc4 + br_offset;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (imem_ack) state_d = EXEC;
            EXEC:    if (exec_done) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (fetch_hit) begin
                instr_q <= imem_rdata;
            end
            if (exec_hit) begin
                pc_q <= next_pc;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            if (exec_hit) begin
                retired_q <= retired_q + 32'd1;
            end
            if ((state_q == FETCH) && !imem_ack) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed steps then random instructions, checked against an
// arithmetic next-PC model. Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        exec_done;
    logic        branch;
    logic        bgtz;
    logic        jal;
    logic        jsp;
    logic        alu_zero;
    logic        alu_gtz;
    logic [31:0] jsp_target;
    logic [31:0] link_pc;
    logic [31:0] pc;
    logic [1:0]  state_dbg;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;
`endif

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .branch      (branch),
        .bgtz        (bgtz),
        .jal         (jal),
        .jsp         (jsp),
        .alu_zero    (alu_zero),
        .alu_gtz     (alu_gtz),
        .jsp_target  (jsp_target),
        .link_pc     (link_pc),
        .pc          (pc),
        .state_dbg   (state_dbg)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int total;
    int bad;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int          m_stall;
    int          m_ret;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_counters();
`ifdef FETCH_PERF_CNT_EN
        check("retired_cnt", retired_cnt, 32'(m_ret));
        check("stall_cnt", stall_cnt, 32'(m_stall));
`endif
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                              input bit f_jsp, input bit f_jal, input bit f_br,
                                              input bit f_bg, input bit f_z, input bit f_g,
                                              input logic [31:0] tgt);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        if (f_jsp) return tgt & 32'hFFFF_FFFC;
        if (f_jal) return (seq & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
        if ((f_br && f_z) || (f_bg && f_g)) begin
            off = int'($signed(ins[15:0])) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    // driver: full fetch (ack after d low cycles) then execute with the given strobes
    task automatic step(input int d, input logic [31:0] rdata, input bit stray_done,
                        input bit f_jsp, input bit f_jal, input bit f_br, input bit f_bg,
                        input bit f_z, input bit f_g, input logic [31:0] tgt);
        int          n;
        logic [31:0] exp_pc;
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", imem_req, 1);
        check("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < d; i++) begin
            exec_done = stray_done;
            tick();
            m_stall++;
            check("req_hold", imem_req, 1);
            check("addr_hold", imem_addr, m_pc);
        end
        exec_done  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_instr    = rdata;
        check("instr_valid", instr_valid, 1);
        check("req_low_exec", imem_req, 0);
        check("instr", instr, m_instr);
        check("opcode", opcode, 32'(m_instr[31:26]));
        check("link_pc", link_pc, m_pc + 32'd4);
        check("pc_exec", pc, m_pc);
        // a stray ack while executing must not disturb the held word
        imem_ack   = 1'b1;
        imem_rdata = ~m_instr;
        tick();
        imem_ack   = 1'b0;
        check("instr_stray_ack", instr, m_instr);
        check("valid_stray_ack", instr_valid, 1);
        branch     = f_br;
        bgtz       = f_bg;
        jal        = f_jal;
        jsp        = f_jsp;
        alu_zero   = f_z;
        alu_gtz    = f_g;
        jsp_target = tgt;
        exec_done  = 1'b1;
        exp_pc = model_next(m_pc, m_instr, f_jsp, f_jal, f_br, f_bg, f_z, f_g, tgt);
        tick();
        exec_done = 1'b0;
        {branch, bgtz, jal, jsp, alu_zero, alu_gtz} = 6'b0;
        jsp_target = $urandom;
        m_pc = exp_pc;
        m_ret++;
        check("next_pc", pc, m_pc);
        check("valid_after_done", instr_valid, 0);
        check_counters();
    endtask

    task automatic plain(input logic [31:0] rdata);
        step(1, rdata, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic go_to(input logic [31:0] tgt);
        step(0, 32'h0, 0, 1, 0, 0, 0, 0, 0, tgt);
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_instr = 32'h0;
        m_stall = 0;
        m_ret   = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        {imem_ack, exec_done, branch, bgtz, jal, jsp, alu_zero, alu_gtz} = 8'b0;
        imem_rdata = 32'h0;
        jsp_target = 32'h0;
        model_reset();
        tick();
        tick();
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_pc", pc, RST_PC);
        check("rst_link", link_pc, RST_PC + 32'd4);
        check("rst_instr", instr, 32'h0);
        check_counters();
        reset = 1'b0;

        // sequential fetches 0,4,8
        plain(32'h0000_0000);
        plain(32'h0000_0000);
        plain(32'h0000_0000);

        // beq taken / not taken from 0x40
        go_to(32'h0000_0040);
        step(1, 32'h1000_0003, 0, 0, 0, 1, 0, 1, 0, 32'h0);
        check("beq_taken", pc, 32'h0000_0050);
        go_to(32'h0000_0040);
        step(1, 32'h1000_0003, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        check("beq_not_taken", pc, 32'h0000_0044);

        // bgtz backward by one word lands on itself
        go_to(32'h0000_0100);
        step(1, 32'h1C00_FFFF, 0, 0, 0, 0, 1, 0, 1, 32'h0);
        check("bgtz_self", pc, 32'h0000_0100);
        // branch and bgtz together, only gtz true
        step(2, 32'h1000_0002, 0, 0, 0, 1, 1, 0, 1, 32'h0);

        // jal region, then jal+jsp with jsp winning
        go_to(32'h1000_0000);
        step(1, 32'h0C00_0040, 0, 0, 1, 0, 0, 0, 0, 32'h0);
        check("jal_target", pc, 32'h1000_0100);
        step(1, 32'h0C00_0040, 0, 1, 1, 0, 0, 0, 0, 32'h0000_0203);
        check("jsp_over_jal", pc, 32'h0000_0200);

        // wrap forward and backward
        go_to(32'hFFFF_FFFD);
        check("jsp_align", pc, 32'hFFFF_FFFC);
        plain(32'h0);
        check("wrap_fwd", pc, 32'h0);
        step(1, 32'h1000_FFFE, 0, 0, 0, 1, 0, 1, 0, 32'h0);
        check("wrap_back", pc, 32'hFFFF_FFFC);

        // long ack delay with stray exec_done during the wait
        step(4, 32'h2000_1234, 1, 0, 0, 0, 0, 0, 0, 32'h0);

        // reset while waiting for ack
        go_to(32'h0000_0800);
        tick();
        tick();
        check("pre_rst_req", imem_req, 1);
        reset = 1'b1;
        #1;
        check("midrst_req", imem_req, 0);
        check("midrst_pc", pc, RST_PC);
        check("midrst_valid", instr_valid, 0);
        model_reset();
        check_counters();
        tick();
        reset = 1'b0;
        plain(32'h0000_0000);
        check("refetch_pc", pc, RST_PC + 32'd4);

        // random instructions, strobes and ack delays
        for (int k = 0; k < 60; k++) begin
            step($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
